// File: rtl/adbg_ahb3_pkg.sv
// Shared types and word-size helpers for the AHB3 debug burst sequencer.
package adbg_ahb3_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWdata,
    StIssue,
    StWait,
    StRpush
  } burst_state_e;

  localparam logic [3:0] WSIZE_BYTE  = 4'd1;
  localparam logic [3:0] WSIZE_HWORD = 4'd2;
  localparam logic [3:0] WSIZE_WORD  = 4'd4;
  localparam logic [3:0] WSIZE_DWORD = 4'd8;

  // Unsupported sizes (and 8 on a 32-bit bus) fall back to the native bus width.
  function automatic logic [3:0] legal_size(input logic [3:0] size,
                                            input int unsigned data_width);
    logic [3:0] native;
    native = 4'(data_width / 8);
    case (size)
      WSIZE_BYTE, WSIZE_HWORD, WSIZE_WORD: legal_size = size;
      WSIZE_DWORD: legal_size = (data_width == 64) ? WSIZE_DWORD : native;
      default:     legal_size = native;
    endcase
  endfunction

endpackage

// File: rtl/adbg_ahb3_burst_ctrl_if.sv
// Command, stream and BIU signals of the burst sequencer.
// ADBG_BURST_ERR_ADDR_EN adds err_addr/err_cnt.
interface adbg_ahb3_burst_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 16
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_rd;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [3:0]            cmd_word_size;
  logic [CNT_WIDTH-1:0]  cmd_count;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_valid;
  logic                  wr_ready;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  rd_ready;
  logic                  busy;
  logic                  done;
  logic                  burst_err;
  logic [ADDR_WIDTH-1:0] biu_addr;
  logic [DATA_WIDTH-1:0] biu_di;
  logic                  biu_strb;
  logic                  biu_rw;
  logic [3:0]            biu_word_size;
  logic [DATA_WIDTH-1:0] biu_do;
  logic                  biu_rdy;
  logic                  biu_err;
`ifdef ADBG_BURST_ERR_ADDR_EN
  logic [ADDR_WIDTH-1:0] err_addr;
  logic [CNT_WIDTH-1:0]  err_cnt;
`endif

  // The sequencer itself.
  modport slave (
    input  cmd_valid, cmd_rd, cmd_addr, cmd_word_size, cmd_count,
    input  wr_data, wr_valid, rd_ready, biu_do, biu_rdy, biu_err,
`ifdef ADBG_BURST_ERR_ADDR_EN
    output err_addr, err_cnt,
`endif
    output cmd_ready, wr_ready, rd_data, rd_valid, busy, done, burst_err,
    output biu_addr, biu_di, biu_strb, biu_rw, biu_word_size
  );

  // Command decoder plus BIU side.
  modport master (
    output cmd_valid, cmd_rd, cmd_addr, cmd_word_size, cmd_count,
    output wr_data, wr_valid, rd_ready, biu_do, biu_rdy, biu_err,
`ifdef ADBG_BURST_ERR_ADDR_EN
    input  err_addr, err_cnt,
`endif
    input  cmd_ready, wr_ready, rd_data, rd_valid, busy, done, burst_err,
    input  biu_addr, biu_di, biu_strb, biu_rw, biu_word_size
  );

endinterface

// File: rtl/adbg_ahb3_wdata_align.sv
// Legalises a word size and moves an LSB-justified word to the MSB end of the bus.
module adbg_ahb3_wdata_align
  import adbg_ahb3_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [3:0]            size_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [3:0]            size_o,
  output logic [DATA_WIDTH-1:0] data_o
);

  int unsigned shamt;

  always_comb begin
    size_o = legal_size(size_i, DATA_WIDTH);
    shamt  = DATA_WIDTH - 32'(size_o) * 8;
    data_o = data_i << shamt;
  end

endmodule

// File: rtl/adbg_ahb3_burst_ctrl.sv
// Burst sequencer feeding the AHB3 BIU one single-word strobe per word.
// Define ADBG_BURST_ERR_ADDR_EN to add first-error address and error count outputs.
module adbg_ahb3_burst_ctrl
  import adbg_ahb3_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                         biu_clk,
  input  logic                         biu_rst,
  adbg_ahb3_burst_ctrl_if.slave        bus_io
);

  burst_state_e          state_q, state_d;
  logic                  rst_done_q;
  logic                  rd_q, rd_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [3:0]            size_q, size_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic [DATA_WIDTH-1:0] di_q, di_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  err_q, err_d;
  logic                  done_q, done_d;
`ifdef ADBG_BURST_ERR_ADDR_EN
  logic [ADDR_WIDTH-1:0] err_addr_q, err_addr_d;
  logic [CNT_WIDTH-1:0]  err_cnt_q, err_cnt_d;
`endif

  logic                  cmd_ready;
  logic [3:0]            align_size_in, align_size;
  logic [DATA_WIDTH-1:0] align_data;

  // In idle the aligner legalises the incoming size; afterwards it aligns write data.
  assign align_size_in = (state_q == StIdle) ? bus_io.cmd_word_size : size_q;

  adbg_ahb3_wdata_align #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_align (
    .size_i (align_size_in),
    .data_i (bus_io.wr_data),
    .size_o (align_size),
    .data_o (align_data)
  );

  assign cmd_ready = rst_done_q & (state_q == StIdle);

  always_comb begin
    state_d   = state_q;
    rd_d      = rd_q;
    addr_d    = addr_q;
    size_d    = size_q;
    count_d   = count_q;
    di_d      = di_q;
    rd_data_d = rd_data_q;
    err_d     = err_q;
    done_d    = 1'b0;
`ifdef ADBG_BURST_ERR_ADDR_EN
    err_addr_d = err_addr_q;
    err_cnt_d  = err_cnt_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (cmd_ready && bus_io.cmd_valid) begin
          rd_d    = bus_io.cmd_rd;
          addr_d  = bus_io.cmd_addr;
          size_d  = align_size;
          count_d = bus_io.cmd_count;
          err_d   = 1'b0;
`ifdef ADBG_BURST_ERR_ADDR_EN
          err_addr_d = '0;
          err_cnt_d  = '0;
`endif
          if (bus_io.cmd_count == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = bus_io.cmd_rd ? StIssue : StWdata;
          end
        end
      end
      StWdata: begin
        if (bus_io.wr_valid) begin
          di_d    = align_data;
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (bus_io.biu_rdy) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (bus_io.biu_rdy) begin
          err_d   = err_q | bus_io.biu_err;
          addr_d  = addr_q + ADDR_WIDTH'(size_q);
          count_d = count_q - CNT_WIDTH'(1);
`ifdef ADBG_BURST_ERR_ADDR_EN
          if (bus_io.biu_err) begin
            if (!err_q) err_addr_d = addr_q;
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_WIDTH'(1);
          end
`endif
          if (rd_q) begin
            rd_data_d = bus_io.biu_do;
            state_d   = StRpush;
          end else if (count_d != '0) begin
            state_d = StWdata;
          end else begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end
      end
      StRpush: begin
        if (bus_io.rd_ready) begin
          if (count_q != '0) begin
            state_d = StIssue;
          end else begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge biu_clk or posedge biu_rst) begin
    if (biu_rst) begin
      state_q    <= StIdle;
      rst_done_q <= 1'b0;
      rd_q       <= 1'b0;
      addr_q     <= '0;
      size_q     <= '0;
      count_q    <= '0;
      di_q       <= '0;
      rd_data_q  <= '0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
`ifdef ADBG_BURST_ERR_ADDR_EN
      err_addr_q <= '0;
      err_cnt_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      rst_done_q <= 1'b1;
      rd_q       <= rd_d;
      addr_q     <= addr_d;
      size_q     <= size_d;
      count_q    <= count_d;
      di_q       <= di_d;
      rd_data_q  <= rd_data_d;
      err_q      <= err_d;
      done_q     <= done_d;
`ifdef ADBG_BURST_ERR_ADDR_EN
      err_addr_q <= err_addr_d;
      err_cnt_q  <= err_cnt_d;
`endif
    end
  end

  assign bus_io.cmd_ready     = cmd_ready;
  assign bus_io.wr_ready      = (state_q == StWdata);
  assign bus_io.rd_valid      = (state_q == StRpush);
  assign bus_io.rd_data       = rd_data_q;
  assign bus_io.busy          = (state_q != StIdle);
  assign bus_io.done          = done_q;
  assign bus_io.burst_err     = err_q;
  assign bus_io.biu_addr      = addr_q;
  assign bus_io.biu_di        = di_q;
  assign bus_io.biu_strb      = (state_q == StIssue) & bus_io.biu_rdy;
  assign bus_io.biu_rw        = rd_q;
  assign bus_io.biu_word_size = size_q;
`ifdef ADBG_BURST_ERR_ADDR_EN
  assign bus_io.err_addr      = err_addr_q;
  assign bus_io.err_cnt       = err_cnt_q;
`endif

endmodule

// File: tb/tb_adbg_ahb3_burst_ctrl.sv
// Scoreboard bench for adbg_ahb3_burst_ctrl with a small BIU responder model.
module tb_adbg_ahb3_burst_ctrl;

  typedef struct {
    logic [31:0] addr;
    logic        rw;
    logic [3:0]  size;
    logic [31:0] di;
  } acc_t;

  typedef struct {
    logic        err;
    logic [31:0] eaddr;
    logic [15:0] ecnt;
  } done_t;

  logic biu_clk = 1'b0;
  logic biu_rst = 1'b1;

  adbg_ahb3_burst_ctrl_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .CNT_WIDTH(16)) bus ();

  adbg_ahb3_burst_ctrl #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .CNT_WIDTH  (16)
  ) dut (
    .biu_clk (biu_clk),
    .biu_rst (biu_rst),
    .bus_io  (bus)
  );

  always #5 biu_clk = ~biu_clk;

  acc_t        exp_acc[$];
  logic [31:0] exp_rd[$];
  done_t       exp_done[$];
  logic [31:0] bq_do[$];
  logic        bq_err[$];

  int n_cmp = 0;
  int n_bad = 0;
  int strb_cnt = 0;
  int done_cnt = 0;
  int lat_cfg = 2;
  int lat_cnt = 0;
  logic [31:0] pend_do;
  logic        pend_err;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_evt(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got event, expected none", name);
  endtask

  task automatic biu_model();
    forever begin
      @(posedge biu_clk or posedge biu_rst);
      if (biu_rst) begin
        bus.biu_rdy <= 1'b1;
        bus.biu_err <= 1'b0;
        lat_cnt = 0;
      end else if (bus.biu_strb) begin
        bus.biu_rdy <= 1'b0;
        bus.biu_err <= 1'b0;
        pend_do  = (bq_do.size() > 0) ? bq_do.pop_front() : 32'h0;
        pend_err = (bq_err.size() > 0) ? bq_err.pop_front() : 1'b0;
        lat_cnt  = lat_cfg;
      end else if (lat_cnt > 0) begin
        lat_cnt--;
        if (lat_cnt == 0) begin
          bus.biu_rdy <= 1'b1;
          bus.biu_do  <= pend_do;
          bus.biu_err <= pend_err;
        end
      end
    end
  endtask

  task automatic monitor();
    acc_t  a;
    done_t d;
    forever begin
      @(negedge biu_clk);
      if (!biu_rst) begin
        if (bus.biu_strb) begin
          strb_cnt++;
          if (exp_acc.size() == 0) fail_evt("unexpected_strobe");
          else begin
            a = exp_acc.pop_front();
            check("biu_addr", 64'(bus.biu_addr), 64'(a.addr));
            check("biu_rw", 64'(bus.biu_rw), 64'(a.rw));
            check("biu_word_size", 64'(bus.biu_word_size), 64'(a.size));
            if (!a.rw) check("biu_di", 64'(bus.biu_di), 64'(a.di));
          end
        end
        if (bus.rd_valid) begin
          if (exp_rd.size() == 0) fail_evt("unexpected_rd_valid");
          else begin
            check("rd_data", 64'(bus.rd_data), 64'(exp_rd[0]));
            if (bus.rd_ready) void'(exp_rd.pop_front());
          end
        end
        if (bus.done) begin
          done_cnt++;
          if (exp_done.size() == 0) fail_evt("unexpected_done");
          else begin
            d = exp_done.pop_front();
            check("burst_err", 64'(bus.burst_err), 64'(d.err));
            check("busy_at_done", 64'(bus.busy), 64'd0);
`ifdef ADBG_BURST_ERR_ADDR_EN
            check("err_addr", 64'(bus.err_addr), 64'(d.eaddr));
            check("err_cnt", 64'(bus.err_cnt), 64'(d.ecnt));
`endif
          end
        end
      end
    end
  endtask

  task automatic exp_a(input logic [31:0] addr, input logic rw, input logic [3:0] size,
                       input logic [31:0] di, input logic [31:0] rdo, input logic err);
    acc_t a;
    a.addr = addr; a.rw = rw; a.size = size; a.di = di;
    exp_acc.push_back(a);
    bq_do.push_back(rdo);
    bq_err.push_back(err);
    if (rw) exp_rd.push_back(rdo);
  endtask

  task automatic exp_d(input logic err, input logic [31:0] eaddr, input logic [15:0] ecnt);
    done_t d;
    d.err = err; d.eaddr = eaddr; d.ecnt = ecnt;
    exp_done.push_back(d);
  endtask

  task automatic send_cmd(input logic rd, input logic [31:0] addr, input logic [3:0] size,
                          input logic [15:0] count);
    int n = 0;
    bus.cmd_rd = rd; bus.cmd_addr = addr; bus.cmd_word_size = size; bus.cmd_count = count;
    bus.cmd_valid = 1'b1;
    while (!bus.cmd_ready && n < 50) begin
      @(posedge biu_clk); #1; n++;
    end
    if (n >= 50) fail_evt("cmd_accept_timeout");
    else begin
      @(posedge biu_clk); #1;
    end
    bus.cmd_valid = 1'b0;
  endtask

  task automatic push_wr(input logic [31:0] data);
    int n = 0;
    bus.wr_data = data;
    bus.wr_valid = 1'b1;
    while (!bus.wr_ready && n < 50) begin
      @(posedge biu_clk); #1; n++;
    end
    if (n >= 50) fail_evt("wr_accept_timeout");
    else begin
      @(posedge biu_clk); #1;
    end
    bus.wr_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_acc.size() + exp_rd.size() + exp_done.size()) != 0 && n < 200) begin
      @(posedge biu_clk); #1; n++;
    end
    if (n >= 200) fail_evt("burst_timeout");
    repeat (2) @(posedge biu_clk);
    #1;
  endtask

  initial begin
    int s0;
    int d0;
    int n;
    bus.cmd_valid = 1'b0; bus.cmd_rd = 1'b0; bus.cmd_addr = '0;
    bus.cmd_word_size = 4'd4; bus.cmd_count = '0;
    bus.wr_data = '0; bus.wr_valid = 1'b0; bus.rd_ready = 1'b1;
    bus.biu_do = '0; bus.biu_rdy = 1'b1; bus.biu_err = 1'b0;
    fork
      biu_model();
      monitor();
    join_none

    // Reset values.
    repeat (3) @(posedge biu_clk);
    #1;
    check("rst_cmd_ready", 64'(bus.cmd_ready), 64'd0);
    check("rst_wr_ready", 64'(bus.wr_ready), 64'd0);
    check("rst_rd_valid", 64'(bus.rd_valid), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_biu_strb", 64'(bus.biu_strb), 64'd0);
    check("rst_biu_word_size", 64'(bus.biu_word_size), 64'd0);
    check("rst_biu_addr", 64'(bus.biu_addr), 64'd0);
    biu_rst = 1'b0;
    check("cmd_ready_before_edge", 64'(bus.cmd_ready), 64'd0);
    @(posedge biu_clk); #1;
    check("cmd_ready_after_reset", 64'(bus.cmd_ready), 64'd1);

    // Word write burst.
    exp_a(32'h100, 1'b0, 4'd4, 32'h11111111, 32'h0, 1'b0);
    exp_a(32'h104, 1'b0, 4'd4, 32'h22222222, 32'h0, 1'b0);
    exp_a(32'h108, 1'b0, 4'd4, 32'h33333333, 32'h0, 1'b0);
    exp_d(1'b0, 32'h0, 16'd0);
    send_cmd(1'b0, 32'h100, 4'd4, 16'd3);
    push_wr(32'h11111111);
    push_wr(32'h22222222);
    push_wr(32'h33333333);
    wait_idle();

    // Half-word read burst.
    exp_a(32'h202, 1'b1, 4'd2, 32'h0, 32'h0000BEEF, 1'b0);
    exp_a(32'h204, 1'b1, 4'd2, 32'h0, 32'h0000CAFE, 1'b0);
    exp_d(1'b0, 32'h0, 16'd0);
    send_cmd(1'b1, 32'h202, 4'd2, 16'd2);
    wait_idle();

    // Byte write goes to the top lane.
    exp_a(32'h10, 1'b0, 4'd1, 32'hA5000000, 32'h0, 1'b0);
    exp_d(1'b0, 32'h0, 16'd0);
    send_cmd(1'b0, 32'h10, 4'd1, 16'd1);
    push_wr(32'h000000A5);
    wait_idle();

    // Read with downstream stalled.
    bus.rd_ready = 1'b0;
    exp_a(32'h500, 1'b1, 4'd4, 32'h0, 32'hA1A1A1A1, 1'b0);
    exp_a(32'h504, 1'b1, 4'd4, 32'h0, 32'hA2A2A2A2, 1'b0);
    exp_a(32'h508, 1'b1, 4'd4, 32'h0, 32'hA3A3A3A3, 1'b0);
    exp_d(1'b0, 32'h0, 16'd0);
    send_cmd(1'b1, 32'h500, 4'd4, 16'd3);
    n = 0;
    while (!bus.rd_valid && n < 50) begin
      @(posedge biu_clk); #1; n++;
    end
    if (n >= 50) fail_evt("rd_valid_timeout");
    s0 = strb_cnt;
    repeat (10) @(posedge biu_clk);
    #1;
    check("stall_strobes", 64'(strb_cnt), 64'(s0));
    check("stall_rd_valid", 64'(bus.rd_valid), 64'd1);
    bus.rd_ready = 1'b1;
    wait_idle();

    // Error on word 2 of 4; burst still completes.
    exp_a(32'h300, 1'b0, 4'd4, 32'h00000001, 32'h0, 1'b0);
    exp_a(32'h304, 1'b0, 4'd4, 32'h00000002, 32'h0, 1'b1);
    exp_a(32'h308, 1'b0, 4'd4, 32'h00000003, 32'h0, 1'b0);
    exp_a(32'h30C, 1'b0, 4'd4, 32'h00000004, 32'h0, 1'b0);
    exp_d(1'b1, 32'h304, 16'd1);
    send_cmd(1'b0, 32'h300, 4'd4, 16'd4);
    for (int i = 1; i <= 4; i++) push_wr(32'(i));
    wait_idle();

    // Zero-count command: done next cycle, no strobe, error flag cleared.
    s0 = strb_cnt;
    exp_d(1'b0, 32'h0, 16'd0);
    send_cmd(1'b0, 32'h600, 4'd4, 16'd0);
    check("zero_count_done", 64'(bus.done), 64'd1);
    wait_idle();
    check("zero_count_strobes", 64'(strb_cnt), 64'(s0));

    // Address wraps silently.
    exp_a(32'hFFFFFFFC, 1'b0, 4'd4, 32'h5A5A5A5A, 32'h0, 1'b0);
    exp_a(32'h00000000, 1'b0, 4'd4, 32'hC3C3C3C3, 32'h0, 1'b0);
    exp_d(1'b0, 32'h0, 16'd0);
    send_cmd(1'b0, 32'hFFFFFFFC, 4'd4, 16'd2);
    push_wr(32'h5A5A5A5A);
    push_wr(32'hC3C3C3C3);
    wait_idle();

    // Size 8 on a 32-bit bus falls back to 4.
    exp_a(32'h400, 1'b0, 4'd4, 32'hDEADBEEF, 32'h0, 1'b0);
    exp_a(32'h404, 1'b0, 4'd4, 32'h01234567, 32'h0, 1'b0);
    exp_d(1'b0, 32'h0, 16'd0);
    send_cmd(1'b0, 32'h400, 4'd8, 16'd2);
    push_wr(32'hDEADBEEF);
    push_wr(32'h01234567);
    wait_idle();

    // Reset while waiting on the BIU.
    lat_cfg = 6;
    exp_a(32'h700, 1'b1, 4'd4, 32'h0, 32'h77777777, 1'b0);
    exp_d(1'b0, 32'h0, 16'd0);
    s0 = strb_cnt;
    d0 = done_cnt;
    send_cmd(1'b1, 32'h700, 4'd4, 16'd2);
    n = 0;
    while (strb_cnt == s0 && n < 50) begin
      @(posedge biu_clk); #1; n++;
    end
    if (n >= 50) fail_evt("strobe_timeout");
    @(posedge biu_clk); #1;
    check("busy_in_wait", 64'(bus.busy), 64'd1);
    biu_rst = 1'b1;
    #1;
    check("mid_rst_strb", 64'(bus.biu_strb), 64'd0);
    check("mid_rst_busy", 64'(bus.busy), 64'd0);
    check("mid_rst_rd_data", 64'(bus.rd_data), 64'd0);
    exp_acc.delete(); exp_rd.delete(); exp_done.delete(); bq_do.delete(); bq_err.delete();
    repeat (2) @(posedge biu_clk);
    #1;
    biu_rst = 1'b0;
    repeat (10) @(posedge biu_clk);
    #1;
    check("no_done_after_rst", 64'(done_cnt), 64'(d0));
    check("cmd_ready_after_mid_rst", 64'(bus.cmd_ready), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
